// File: rtl/mod_a_arb.sv
// Round-robin front end sharing one registered adder among NUM_REQ clients.
// Ports: clk/rst, i_en, per-client valid/a/b in, o_req_ready one-hot grant,
//        o_add_* issue to the adder, i_add_* adder result back,
//        o_res_valid/o_res_data routed result, o_err sticky protocol error.
module mod_a_arb #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*DW-1:0] i_req_a,
    input  logic [NUM_REQ*DW-1:0] i_req_b,
    output logic [NUM_REQ-1:0]    o_req_ready,
    output logic                  o_add_valid,
    output logic [DW-1:0]         o_add_a,
    output logic [DW-1:0]         o_add_b,
    input  logic                  i_add_valid,
    input  logic [DW-1:0]         i_add_out,
    output logic [NUM_REQ-1:0]    o_res_valid,
    output logic [DW-1:0]         o_res_data,
    output logic                  o_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(LAT + 2);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      scan_idx;
    logic [PW-1:0]      gnt_idx;
    logic               xfer;
    logic [NUM_REQ-1:0] grant;

    logic               add_valid_q, add_valid_d;
    logic [DW-1:0]      add_a_q, add_a_d;
    logic [DW-1:0]      add_b_q, add_b_d;

    logic [LAT:0]       tag_v_q, tag_v_d;
    logic [PW-1:0]      tag_id_q [LAT+1];
    logic [PW-1:0]      tag_id_d [LAT+1];

    logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
    logic [DW-1:0]      res_data_q, res_data_d;
    logic               err_q, err_d;
    // Counts down after reset; while nonzero, stale adder output from
    // operations issued before reset is dropped without flagging an error.
    logic [BW-1:0]      blind_q, blind_d;
    logic               res_hit;

    // Grant: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        scan_idx = '0;
        xfer     = 1'b0;
        if (i_en && !rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scan_idx = PW'((int'(ptr_q) + i) % NUM_REQ);
                if (!xfer && i_req_valid[scan_idx]) begin
                    xfer    = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
            if (xfer) begin
                grant[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        add_valid_d = xfer;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        if (xfer) begin
            ptr_d   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
            add_a_d = i_req_a[int'(gnt_idx)*DW +: DW];
            add_b_d = i_req_b[int'(gnt_idx)*DW +: DW];
        end
    end

    // Owner tags ride alongside the adder so the last stage lines up
    // with the adder's output strobe.
    always_comb begin
        tag_v_d[0]  = xfer;
        tag_id_d[0] = gnt_idx;
        for (int i = 1; i <= LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_comb begin
        res_hit     = i_add_valid && tag_v_q[LAT];
        res_valid_d = '0;
        res_data_d  = res_data_q;
        if (res_hit) begin
            res_valid_d[tag_id_q[LAT]] = 1'b1;
            res_data_d                 = i_add_out;
        end
        blind_d = (blind_q != '0) ? blind_q - BW'(1) : '0;
        err_d   = err_q;
        if (blind_q == '0 && (i_add_valid != tag_v_q[LAT])) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            tag_v_q     <= '0;
            for (int i = 0; i <= LAT; i++) begin
                tag_id_q[i] <= '0;
            end
            res_valid_q <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            blind_q     <= BW'(LAT + 1);
        end else begin
            ptr_q       <= ptr_d;
            add_valid_q <= add_valid_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            blind_q     <= blind_d;
        end
    end

    assign o_req_ready = grant;
    assign o_add_valid = add_valid_q;
    assign o_add_a     = add_a_q;
    assign o_add_b     = add_b_q;
    assign o_res_valid = res_valid_q;
    assign o_res_data  = res_data_q;
    assign o_err       = err_q;

endmodule

// File: doc/mod_a_arb.md
Name: mod_a_arb

Overview:
- Round-robin arbiter/sequencer that shares one mod_a-style adder (registered sum, fixed latency) among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the adder.
- Tracks the owner of each in-flight operation and returns each sum to its own requester.
- Sits between the client blocks and the single adder instance, and owns all issue ordering.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 8, operand/result width; must match the adder.
- LAT, 1, adder latency in cycles from its i_valid to its o_valid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_en  in  1  grant enable; 0 = no new grants (in-flight ops still complete)
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_a  in  NUM_REQ*DW  operand a; requester k uses bits [k*DW +: DW]
- i_req_b  in  NUM_REQ*DW  operand b, same packing
- o_req_ready  out  NUM_REQ  one-hot grant; combinational
- o_add_valid  out  1  registered issue strobe to the adder's i_valid
- o_add_a  out  DW  registered operand a to the adder
- o_add_b  out  DW  registered operand b to the adder
- i_add_valid  in  1  adder o_valid
- i_add_out  in  DW  adder o_out
- o_res_valid  out  NUM_REQ  one-hot result strobe, registered
- o_res_data  out  DW  result data, registered
- o_err  out  1  sticky protocol error

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - o_add_valid=0, o_add_a=0, o_add_b=0.
  - o_res_valid=0, o_res_data=0, o_err=0.
  - Round-robin pointer=0; all tag pipeline entries invalid.
- Reset mid-operation discards all in-flight tags. Adder outputs arriving after reset are ignored and do not set o_err.
- Grant logic:
  - When i_en=1, scan i_req_valid starting at the pointer index, wrapping at NUM_REQ-1 -> 0.
  - The first set bit is granted: o_req_ready=onehot(k).
  - When i_en=0, or no request is valid, o_req_ready=0.
  - o_req_ready never asserts while rst=1.
- Handshake:
  - A transfer occurs when i_req_valid[k] & o_req_ready[k].
  - A requester must hold valid and operands stable until the transfer.
  - Valid may not be withdrawn before transfer; doing so is out of contract.
- Issue: on transfer at cycle t, at t+1 o_add_valid=1, o_add_a/o_add_b = requester k's operands, and the pointer becomes (k+1) mod NUM_REQ. With no transfer, o_add_valid=0, operands hold their previous values, and the pointer is unchanged.
- Throughput: one issue per cycle; back-to-back grants to different requesters are allowed. A lone requester is granted every cycle.
- Tag pipeline:
  - LAT+1 stage shift register of {valid, id}; it shifts every cycle.
  - Stage 0 loads {transfer, k}.
  - The last stage aligns with the adder's o_valid at t+1+LAT.
- Return: when i_add_valid=1 and the last tag stage is valid with id j, at the next edge o_res_valid=onehot(j) and o_res_data=i_add_out (plain DW-bit wrap-around sum, carry dropped). Otherwise o_res_valid=0 and o_res_data holds.
- Latency: handshake at t -> o_res_valid at t+LAT+2 (t+3 for LAT=1).
- Result ordering equals grant order; no result backpressure, so requesters must accept o_res_valid in the cycle it is shown.
- Error: o_err sets when i_add_valid differs from the last tag stage's valid bit. It stays set until rst.
- Simultaneous events: a grant and a returning result in the same cycle are independent. i_en falling does not cancel a transfer already completed that cycle.

Test Plan:
- Single op: after reset, req0 a=8'h12, b=8'h34 with i_en=1 -> ready[0] same cycle; o_add_valid, a=8'h12, b=8'h34 at t+1; o_res_valid=4'b0001, data=8'h46 at t+3.
- Wrap-around sum: req2 a=8'hF0, b=8'h20 -> o_res_valid=4'b0100, data=8'h10; o_err=0.
- Round-robin fairness: all four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; results return in that order with matching one-hot and sums.
- Pointer skip: after granting 1, only req0 and req3 valid -> req3 granted first, then req0.
- i_en=0 with req1 valid -> ready=0 and no o_add_valid. Raising i_en -> grant the next cycle; in-flight results still return while i_en=0.
- Reset mid-flight: assert rst one cycle after a grant -> o_res_valid stays 0 and o_err=0 after reset. Separately, a spurious i_add_valid=1 with an empty tag pipeline -> o_err=1, held until rst.
